// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH / DECODE / EXEC control sequencer.
// State and the retired-instruction counter are registered; datapath
// enables are decoded from the current state, the instruction register,
// mem_ready and the ALU flags, so they respond within the same cycle.
// Optional HALT support is compiled in with the macro CTRL_HALT_EN.
module ctrl_sequencer #(
    parameter  int WIDTH  = 8,
    parameter  int RSEL_W = 2,
    localparam int IR_W   = 4 + 2 * RSEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              zero,
    input  logic              negative,
    input  logic [IR_W-1:0]   irvalue,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              irload,
    output logic              imload,
    output logic              pcsel,
    output logic              pcload,
    output logic              readwrite,
    output logic              dwrite,
    output logic [RSEL_W-1:0] dregsel,
    output logic [RSEL_W-1:0] sregsel,
    output logic [1:0]        aluop,
    output logic [1:0]        regsel,
    output logic [1:0]        addrsel,
    output logic [1:0]        phase,
    output logic [WIDTH-1:0]  instr_count,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALT   = 2'b11
    } state_t;

    localparam logic [1:0] REG_IMM  = 2'b00;
    localparam logic [1:0] REG_SBUS = 2'b01;
    localparam logic [1:0] REG_DIN  = 2'b10;
    localparam logic [1:0] REG_ALU  = 2'b11;

    localparam logic [1:0] ADDR_PC   = 2'b00;
    localparam logic [1:0] ADDR_IMM  = 2'b01;
    localparam logic [1:0] ADDR_SBUS = 2'b10;

    state_t     state;
    logic [3:0] opcode;
    logic       two_word;
    logic       is_mem;
    logic       cond;
    logic       exec_done;

    assign opcode   = irvalue[IR_W-1 -: 4];
    assign two_word = opcode[3];
    assign is_mem   = (opcode == 4'b0100) || (opcode == 4'b0101) ||
                      (opcode == 4'b1101) || (opcode == 4'b1110);

    // Register-select and ALU-op fields are straight slices of the IR.
    assign dregsel = irvalue[2*RSEL_W-1 -: RSEL_W];
    assign sregsel = irvalue[RSEL_W-1:0];
    assign aluop   = opcode[1:0];
    assign phase   = state;

    // Jump condition from the flags; only consumed in the EXEC cycle.
    always_comb begin
        unique case (opcode[1:0])
            2'b00:   cond = zero;
            2'b01:   cond = ~zero;
            2'b10:   cond = ~zero & ~negative;
            default: cond = negative;
        endcase
    end

    assign exec_done = is_mem ? mem_ready : 1'b1;

    // State sequencing and retired-instruction counting.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_ready) state <= DECODE;
                end
                DECODE: begin
                    if (!two_word || mem_ready) state <= EXEC;
                end
                EXEC: begin
                    if (exec_done) begin
`ifdef CTRL_HALT_EN
                        if (opcode == 4'b0111) begin
                            state <= HALT;
                        end else begin
                            state       <= FETCH;
                            instr_count <= instr_count + WIDTH'(1);
                        end
`else
                        state       <= FETCH;
                        instr_count <= instr_count + WIDTH'(1);
`endif
                    end
                end
                default: state <= state;
            endcase
        end
    end

`ifdef CTRL_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    // Datapath enables decoded per state; forced idle while rst_n is low so
    // an in-flight access is abandoned the moment reset asserts.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        mem_req   = 1'b0;
        irload    = 1'b0;
        imload    = 1'b0;
        pcsel     = 1'b0;
        pcload    = 1'b0;
        readwrite = 1'b0;
        dwrite    = 1'b0;
        regsel    = REG_IMM;
        addrsel   = ADDR_PC;
        if (rst_n) begin
            unique case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    addrsel = ADDR_PC;
                    pcsel   = 1'b1;
                    irload  = mem_ready;
                    pcload  = mem_ready;
                end
                DECODE: begin
                    if (two_word) begin
                        mem_req = 1'b1;
                        addrsel = ADDR_PC;
                        pcsel   = 1'b1;
                        imload  = mem_ready;
                        pcload  = mem_ready;
                    end
                end
                EXEC: begin
                    casez (opcode)
                        4'b00??: begin
                            regsel = REG_ALU;
                            dwrite = 1'b1;
                        end
                        4'b0100: begin
                            mem_req = 1'b1;
                            addrsel = ADDR_SBUS;
                            regsel  = REG_DIN;
                            dwrite  = mem_ready;
                        end
                        4'b0101: begin
                            mem_req   = 1'b1;
                            addrsel   = ADDR_SBUS;
                            readwrite = mem_ready;
                        end
                        4'b0110: begin
                            regsel = REG_SBUS;
                            dwrite = 1'b1;
                        end
                        4'b10??: begin
                            pcsel  = 1'b0;
                            pcload = cond;
                        end
                        4'b1100: begin
                            regsel = REG_IMM;
                            dwrite = 1'b1;
                        end
                        4'b1101: begin
                            mem_req   = 1'b1;
                            addrsel   = ADDR_IMM;
                            readwrite = mem_ready;
                        end
                        4'b1110: begin
                            mem_req = 1'b1;
                            addrsel = ADDR_IMM;
                            regsel  = REG_DIN;
                            dwrite  = mem_ready;
                        end
                        4'b1111: begin
                            pcsel  = 1'b0;
                            pcload = 1'b1;
                        end
                        default: ; // 0111: HALT entry or NOP, no enables
                    endcase
                end
                default: ; // HALT: everything idle
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: per-cycle vector table for the main
// instruction mix, plus hand-written sequences for reset, counter wrap
// and HALT (HALT checks follow the CTRL_HALT_EN macro).
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       zero, negative, mem_ready;
    logic [7:0] irvalue;
    logic       mem_req, irload, imload, pcsel, pcload, readwrite, dwrite;
    logic [1:0] dregsel, sregsel, aluop, regsel, addrsel, phase;
    logic [7:0] instr_count;
    logic       halted;

    int total = 0;
    int bad   = 0;

    ctrl_sequencer #(.WIDTH(8), .RSEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .zero(zero), .negative(negative),
        .irvalue(irvalue), .mem_ready(mem_ready), .mem_req(mem_req),
        .irload(irload), .imload(imload), .pcsel(pcsel), .pcload(pcload),
        .readwrite(readwrite), .dwrite(dwrite), .dregsel(dregsel),
        .sregsel(sregsel), .aluop(aluop), .regsel(regsel), .addrsel(addrsel),
        .phase(phase), .instr_count(instr_count), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1);
    end

    // en packing: {mem_req, irload, imload, pcsel, pcload, readwrite, dwrite}
    localparam logic [6:0] EN_NONE = 7'b0000000;
    localparam logic [6:0] EN_FR   = 7'b1101100; // fetch, memory ready
    localparam logic [6:0] EN_FW   = 7'b1001000; // fetch/decode, waiting
    localparam logic [6:0] EN_D2   = 7'b1011100; // decode imm word, ready
    localparam logic [6:0] EN_DW   = 7'b0000001;
    localparam logic [6:0] EN_MEM  = 7'b1000000;
    localparam logic [6:0] EN_LD   = 7'b1000001;
    localparam logic [6:0] EN_ST   = 7'b1000010;
    localparam logic [6:0] EN_PCL  = 7'b0000100;

    typedef struct {
        logic [7:0] ir;
        logic       mr, z, n;
        logic [1:0] ph;
        logic [6:0] en;
        logic [1:0] rs, as;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] en_now();
        return {mem_req, irload, imload, pcsel, pcload, readwrite, dwrite};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] ir, input logic mr, z, n,
                       input logic [1:0] ph, input logic [6:0] en,
                       input logic [1:0] rs, as, input logic [7:0] cnt);
        vec_t v;
        v.ir = ir; v.mr = mr; v.z = z; v.n = n; v.ph = ph; v.en = en;
        v.rs = rs; v.as = as; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; negative = 1'b0;
        irvalue = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One zero-wait 1-word ALU instruction, three cycles, no checks.
    task automatic run_nop();
        irvalue = 8'h00;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // 0x1E ALU op rd=3 rs=2
        add(8'h1E,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd0);
        add(8'h1E,1,0,0, 2'd1, EN_NONE, 2'd0,2'd0, 8'd0);
        add(8'h1E,1,0,0, 2'd2, EN_DW,   2'd3,2'd0, 8'd0);
        // 0xC5 load imm, fetch and decode wait states
        add(8'hC5,0,0,0, 2'd0, EN_FW,   2'd0,2'd0, 8'd1);
        add(8'hC5,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd1);
        add(8'hC5,0,0,0, 2'd1, EN_FW,   2'd0,2'd0, 8'd1);
        add(8'hC5,1,0,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd1);
        add(8'hC5,0,0,0, 2'd2, EN_DW,   2'd0,2'd0, 8'd1);
        // 0xD0 store to mem[imm], one EXEC wait
        add(8'hD0,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd2);
        add(8'hD0,1,0,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd2);
        add(8'hD0,0,0,0, 2'd2, EN_MEM,  2'd0,2'd1, 8'd2);
        add(8'hD0,1,0,0, 2'd2, EN_ST,   2'd0,2'd1, 8'd2);
        // 0xE0 load mem[imm]
        add(8'hE0,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd3);
        add(8'hE0,1,0,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd3);
        add(8'hE0,1,0,0, 2'd2, EN_LD,   2'd2,2'd1, 8'd3);
        // 0x60 move (decode with mem_ready low still advances)
        add(8'h60,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd4);
        add(8'h60,0,0,0, 2'd1, EN_NONE, 2'd0,2'd0, 8'd4);
        add(8'h60,0,0,0, 2'd2, EN_DW,   2'd1,2'd0, 8'd4);
        // 0x50 store dbus to mem[sbus]
        add(8'h50,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd5);
        add(8'h50,1,0,0, 2'd1, EN_NONE, 2'd0,2'd0, 8'd5);
        add(8'h50,1,0,0, 2'd2, EN_ST,   2'd0,2'd2, 8'd5);
        // jumps: 0x80 z=1, 0x80 z=0, 0xB0 n=1, 0x90 z=0, 0xA0 n=1, 0xF0
        add(8'h80,1,1,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd6);
        add(8'h80,1,1,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd6);
        add(8'h80,1,1,0, 2'd2, EN_PCL,  2'd0,2'd0, 8'd6);
        add(8'h80,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd7);
        add(8'h80,1,0,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd7);
        add(8'h80,1,0,0, 2'd2, EN_NONE, 2'd0,2'd0, 8'd7);
        add(8'hB0,1,0,1, 2'd0, EN_FR,   2'd0,2'd0, 8'd8);
        add(8'hB0,1,0,1, 2'd1, EN_D2,   2'd0,2'd0, 8'd8);
        add(8'hB0,1,0,1, 2'd2, EN_PCL,  2'd0,2'd0, 8'd8);
        add(8'h90,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd9);
        add(8'h90,1,0,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd9);
        add(8'h90,1,0,0, 2'd2, EN_PCL,  2'd0,2'd0, 8'd9);
        add(8'hA0,1,0,1, 2'd0, EN_FR,   2'd0,2'd0, 8'd10);
        add(8'hA0,1,0,1, 2'd1, EN_D2,   2'd0,2'd0, 8'd10);
        add(8'hA0,1,0,1, 2'd2, EN_NONE, 2'd0,2'd0, 8'd10);
        add(8'hF0,1,1,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd11);
        add(8'hF0,1,1,0, 2'd1, EN_D2,   2'd0,2'd0, 8'd11);
        add(8'hF0,1,1,0, 2'd2, EN_PCL,  2'd0,2'd0, 8'd11);
        // 0x46 load mem[sbus], three EXEC wait states
        add(8'h46,1,0,0, 2'd0, EN_FR,   2'd0,2'd0, 8'd12);
        add(8'h46,1,0,0, 2'd1, EN_NONE, 2'd0,2'd0, 8'd12);
        add(8'h46,0,0,0, 2'd2, EN_MEM,  2'd2,2'd2, 8'd12);
        add(8'h46,0,0,0, 2'd2, EN_MEM,  2'd2,2'd2, 8'd12);
        add(8'h46,0,0,0, 2'd2, EN_MEM,  2'd2,2'd2, 8'd12);
        add(8'h46,1,0,0, 2'd2, EN_LD,   2'd2,2'd2, 8'd12);

        // ---------------- reset state ----------------
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; negative = 1'b0;
        irvalue = 8'h1E;
        @(negedge clk);
        #1;
        check("reset en", 32'(en_now()), 32'(EN_NONE));
        check("reset regsel", 32'(regsel), 32'd0);
        check("reset addrsel", 32'(addrsel), 32'd0);
        check("reset phase", 32'(phase), 32'd0);
        check("reset count", 32'(instr_count), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("field aluop 1E", 32'(aluop), 32'd1);
        check("field dregsel 1E", 32'(dregsel), 32'd3);
        check("field sregsel 1E", 32'(sregsel), 32'd2);
        irvalue = 8'h46;
        #1;
        check("field aluop 46", 32'(aluop), 32'd0);
        check("field dregsel 46", 32'(dregsel), 32'd1);
        check("field sregsel 46", 32'(sregsel), 32'd2);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            irvalue = vecs[i].ir; mem_ready = vecs[i].mr;
            zero = vecs[i].z; negative = vecs[i].n;
            #1;
            check($sformatf("row%0d phase", i), 32'(phase), 32'(vecs[i].ph));
            check($sformatf("row%0d en", i), 32'(en_now()), 32'(vecs[i].en));
            check($sformatf("row%0d regsel", i), 32'(regsel), 32'(vecs[i].rs));
            check($sformatf("row%0d addrsel", i), 32'(addrsel), 32'(vecs[i].as));
            check($sformatf("row%0d count", i), 32'(instr_count), 32'(vecs[i].cnt));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("table end phase", 32'(phase), 32'd0);
        check("table end count", 32'(instr_count), 32'd13);

        // ---------------- counter wrap ----------------
        do_reset();
        for (int k = 0; k < 255; k++) run_nop();
        mem_ready = 1'b0;
        #1;
        check("wrap count 255", 32'(instr_count), 32'hFF);
        @(negedge clk);
        run_nop();
        mem_ready = 1'b0;
        #1;
        check("wrap count 0", 32'(instr_count), 32'h00);
        check("wrap phase", 32'(phase), 32'd0);

        // ---------------- async reset clears count ----------------
        do_reset();
        @(negedge clk);
        run_nop();
        run_nop();
        mem_ready = 1'b0;
        #1;
        check("pre-reset count", 32'(instr_count), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async count clear", 32'(instr_count), 32'd0);
        check("async en drop", 32'(en_now()), 32'(EN_NONE));

        // ---------------- reset during DECODE wait ----------------
        do_reset();
        @(negedge clk);
        irvalue = 8'hC0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("dwait phase", 32'(phase), 32'd1);
        check("dwait en", 32'(en_now()), 32'(EN_FW));
        #1 rst_n = 1'b0;
        #1;
        check("dwait rst en", 32'(en_now()), 32'(EN_NONE));
        check("dwait rst phase", 32'(phase), 32'd0);
        check("dwait rst count", 32'(instr_count), 32'd0);
        @(negedge clk);
        #1;
        check("dwait held en", 32'(en_now()), 32'(EN_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset fetch en", 32'(en_now()), 32'(EN_FW));
        check("post-reset phase", 32'(phase), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("post-reset fetch ready", 32'(en_now()), 32'(EN_FR));

        // ---------------- opcode 0111 ----------------
        do_reset();
        @(negedge clk);
        irvalue = 8'h70; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("op7 decode en", 32'(en_now()), 32'(EN_NONE));
        @(negedge clk);
        #1;
        check("op7 exec phase", 32'(phase), 32'd2);
        check("op7 exec en", 32'(en_now()), 32'(EN_NONE));
`ifdef CTRL_HALT_EN
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("halt%0d halted", c), 32'(halted), 32'd1);
            check($sformatf("halt%0d en", c), 32'(en_now()), 32'(EN_NONE));
            check($sformatf("halt%0d phase", c), 32'(phase), 32'd3);
        end
        check("halt count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("halt reset phase", 32'(phase), 32'd0);
        check("halt reset halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("nop7 phase", 32'(phase), 32'd0);
        check("nop7 count", 32'(instr_count), 32'd1);
        check("nop7 halted", 32'(halted), 32'd0);
        check("nop7 fetch en", 32'(en_now()), 32'(EN_FW));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
